// File: rtl/dht_responder_pkg.sv
// Shared definitions for the DHT single-wire sensor responder:
// state encoding, default bus timing (1 cycle = 1 us) and the checksum helper.
package dht_responder_pkg;

   localparam int unsigned T_START_MIN_DEF = 500;
   localparam int unsigned T_REL_DLY_DEF   = 30;
   localparam int unsigned T_ACK_DEF       = 80;
   localparam int unsigned T_BIT_LOW_DEF   = 50;
   localparam int unsigned T_ZERO_DEF      = 26;
   localparam int unsigned T_ONE_DEF       = 70;

   localparam int unsigned FRAME_BITS = 40;
   // Cycles at the start of a released phase during which our own low is still in the synchronizer
   localparam int unsigned COL_SLACK  = 3;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_HOST_LOW = 3'd1;
   localparam logic [2:0] ST_REL_WAIT = 3'd2;
   localparam logic [2:0] ST_ACK_LO   = 3'd3;
   localparam logic [2:0] ST_ACK_HI   = 3'd4;
   localparam logic [2:0] ST_BIT_LO   = 3'd5;
   localparam logic [2:0] ST_BIT_HI   = 3'd6;
   localparam logic [2:0] ST_END_LO   = 3'd7;

   function automatic logic [7:0] dht_csum(input logic [15:0] h,
                                           input logic [15:0] t,
                                           input logic        inv);
      logic [7:0] s;
      s = h[15:8] + h[7:0] + t[15:8] + t[7:0];
      return inv ? ~s : s;
   endfunction

endpackage

// File: rtl/dht_sync2.sv
// Two-flop synchronizer for the bus level; resets to 1 so a released bus
// never looks like a falling edge when reset ends.
module dht_sync2 (
   input  logic clk1M,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk1M or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/dht_responder.sv
// DHT-style sensor emulator: waits for a host start pulse, then answers with
// an acknowledge and a 40-bit {hum, temp, csum} frame on the open-drain bus.
module dht_responder
   import dht_responder_pkg::*;
#(
   parameter int unsigned T_START_MIN = T_START_MIN_DEF,
   parameter int unsigned T_REL_DLY   = T_REL_DLY_DEF,
   parameter int unsigned T_ACK       = T_ACK_DEF,
   parameter int unsigned T_BIT_LOW   = T_BIT_LOW_DEF,
   parameter int unsigned T_ZERO      = T_ZERO_DEF,
   parameter int unsigned T_ONE       = T_ONE_DEF
) (
   input  logic        clk1M,
   input  logic        rst_n,
   input  logic        data_in,
   output logic        data_oe,
   input  logic [15:0] hum,
   input  logic [15:0] temp,
   input  logic        csum_err_inj,
   output logic        busy,
   output logic        frame_done,
   output logic        collision
);

   localparam logic [15:0] START_MIN = 16'(T_START_MIN);
   localparam logic [15:0] REL_END   = 16'(T_REL_DLY - 1);
   localparam logic [15:0] ACK_END   = 16'(T_ACK - 1);
   localparam logic [15:0] LOW_END   = 16'(T_BIT_LOW - 1);
   localparam logic [15:0] ZERO_END  = 16'(T_ZERO - 1);
   localparam logic [15:0] ONE_END   = 16'(T_ONE - 1);
   localparam logic [15:0] SLACK     = 16'(COL_SLACK);
   localparam logic [5:0]  LAST_BIT  = 6'(FRAME_BITS - 1);

   logic        sd;
   logic        sd_prev_q;
   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [5:0]  bit_idx_q, bit_idx_d;
   logic [39:0] frame_q, frame_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        col_q, col_d;
   logic        col_hit;
   logic [15:0] hi_end;

   dht_sync2 u_sync (
      .clk1M (clk1M),
      .rst_n (rst_n),
      .d_i   (data_in),
      .q_o   (sd)
   );

   // Frame is shifted left after every bit, so the bit on the wire is always the MSB
   assign hi_end  = frame_q[39] ? ONE_END : ZERO_END;
   assign col_hit = !sd && (cnt_q >= SLACK);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 16'd1;
      bit_idx_d = bit_idx_q;
      frame_d   = frame_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      col_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = cnt_q;
            if (sd_prev_q && !sd) begin
               state_d = ST_HOST_LOW;
               cnt_d   = 16'd0;
            end
         end
         ST_HOST_LOW: begin
            if (sd) begin
               cnt_d = 16'd0;
               if (cnt_q >= START_MIN) begin
                  state_d   = ST_REL_WAIT;
                  frame_d   = {hum, temp, dht_csum(hum, temp, csum_err_inj)};
                  bit_idx_d = 6'd0;
                  busy_d    = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (cnt_q == 16'hFFFF) begin
               cnt_d = cnt_q;
            end
         end
         ST_REL_WAIT: begin
            if (cnt_q == REL_END) begin
               state_d = ST_ACK_LO;
               cnt_d   = 16'd0;
            end
         end
         ST_ACK_LO: begin
            if (cnt_q == ACK_END) begin
               state_d = ST_ACK_HI;
               cnt_d   = 16'd0;
            end
         end
         ST_ACK_HI: begin
            if (col_hit) begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
               busy_d  = 1'b0;
               col_d   = 1'b1;
            end else if (cnt_q == ACK_END) begin
               state_d = ST_BIT_LO;
               cnt_d   = 16'd0;
            end
         end
         ST_BIT_LO: begin
            if (cnt_q == LOW_END) begin
               state_d = ST_BIT_HI;
               cnt_d   = 16'd0;
            end
         end
         ST_BIT_HI: begin
            if (col_hit) begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
               busy_d  = 1'b0;
               col_d   = 1'b1;
            end else if (cnt_q == hi_end) begin
               cnt_d   = 16'd0;
               frame_d = {frame_q[38:0], 1'b0};
               if (bit_idx_q == LAST_BIT) begin
                  state_d = ST_END_LO;
               end else begin
                  state_d   = ST_BIT_LO;
                  bit_idx_d = bit_idx_q + 6'd1;
               end
            end
         end
         ST_END_LO: begin
            if (cnt_q == LOW_END) begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk1M or negedge rst_n) begin
      if (!rst_n) begin
         sd_prev_q <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= 16'd0;
         bit_idx_q <= 6'd0;
         frame_q   <= 40'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         col_q     <= 1'b0;
      end else begin
         sd_prev_q <= sd;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         frame_q   <= frame_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         col_q     <= col_d;
      end
   end

   // Decoded straight from the state register so an async reset releases the bus at once
   assign data_oe    = (state_q == ST_ACK_LO) || (state_q == ST_BIT_LO) || (state_q == ST_END_LO);
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign collision  = col_q;

endmodule

// File: tb/tb_dht_responder.sv
// Directed bench for dht_responder: plays the host side of the bus and
// decodes the responder's low/high run lengths back into a 40-bit frame.
`timescale 1ns/1ps
module tb_dht_responder;

   logic        clk1M = 1'b0;
   logic        rst_n = 1'b0;
   logic        data_in;
   logic        data_oe;
   logic [15:0] hum = 16'h028C;
   logic [15:0] temp = 16'h010F;
   logic        csum_err_inj = 1'b0;
   logic        busy;
   logic        frame_done;
   logic        collision;
   logic        host_low = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;
   int n_col    = 0;
   int n_both   = 0;

   dht_responder dut (
      .clk1M        (clk1M),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .data_oe      (data_oe),
      .hum          (hum),
      .temp         (temp),
      .csum_err_inj (csum_err_inj),
      .busy         (busy),
      .frame_done   (frame_done),
      .collision    (collision)
   );

   always #500 clk1M = ~clk1M;

   // Open-drain bus with pull-up: low if either side pulls
   assign data_in = ~(data_oe | host_low);

   always @(negedge clk1M) begin
      if (frame_done === 1'b1) n_done++;
      if (collision === 1'b1) n_col++;
      if (frame_done === 1'b1 && collision === 1'b1) n_both++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic measure_run(input logic lvl, output int len);
      len = 1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk1M);
         if (data_oe !== lvl) return;
         len++;
      end
      chk("run_bound", 64'(len), 64'd0);
   endtask

   task automatic start_pulse(input int us);
      host_low = 1'b1;
      repeat (us) @(negedge clk1M);
      host_low = 1'b0;
   endtask

   task automatic wait_oe(output int n);
      n = 0;
      while (data_oe !== 1'b1 && n < 2000) begin
         @(negedge clk1M);
         n++;
      end
   endtask

   task automatic do_frame(input string tag, input int chg_bit, input int col_bit,
                           output logic [39:0] got);
      int n, len, d0, c0;
      got = '0;
      d0  = n_done;
      c0  = n_col;
      start_pulse(1000);
      wait_oe(n);
      // 30 us release delay plus synchronizer/edge slack
      chk({tag, "_rel_dly"}, 64'(n >= 31 && n <= 35), 64'd1);
      chk({tag, "_busy_on"}, 64'(busy), 64'd1);
      measure_run(1'b1, len);
      chk({tag, "_ack_lo"}, 64'(len), 64'd80);
      measure_run(1'b0, len);
      chk({tag, "_ack_hi"}, 64'(len), 64'd80);
      for (int i = 0; i < 40; i++) begin
         if (i == chg_bit) hum = 16'hFFFF;
         measure_run(1'b1, len);
         chk({tag, "_bit_lo"}, 64'(len), 64'd50);
         if (i == col_bit) begin
            repeat (20) @(negedge clk1M);
            host_low = 1'b1;
            repeat (10) @(negedge clk1M);
            host_low = 1'b0;
            repeat (5) @(negedge clk1M);
            chk({tag, "_col_pulses"}, 64'(n_col - c0), 64'd1);
            chk({tag, "_col_oe"}, 64'(data_oe), 64'd0);
            chk({tag, "_col_busy"}, 64'(busy), 64'd0);
            chk({tag, "_col_no_done"}, 64'(n_done - d0), 64'd0);
            return;
         end
         measure_run(1'b0, len);
         chk({tag, "_bit_hi_len"}, 64'(len == 26 || len == 70), 64'd1);
         got = {got[38:0], (len > 48)};
      end
      measure_run(1'b1, len);
      chk({tag, "_end_lo"}, 64'(len), 64'd50);
      @(negedge clk1M);
      chk({tag, "_done_once"}, 64'(n_done - d0), 64'd1);
      chk({tag, "_no_col"}, 64'(n_col - c0), 64'd0);
      chk({tag, "_busy_off"}, 64'(busy), 64'd0);
      chk({tag, "_oe_off"}, 64'(data_oe), 64'd0);
   endtask

   initial begin
      logic [39:0] got;
      int          n, d0, c0;
      logic        seen;

      repeat (3) @(negedge clk1M);
      chk("rst_oe", 64'(data_oe), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(frame_done), 64'd0);
      chk("rst_col", 64'(collision), 64'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk1M);

      // 0x02+0x8C+0x01+0x0F = 0x9E
      do_frame("nominal", -1, -1, got);
      chk("nominal_frame", 64'(got), 64'h028C010F9E);
      $display("nominal frame 0x%010h", got);
      repeat (20) @(negedge clk1M);

      d0   = n_done;
      c0   = n_col;
      seen = 1'b0;
      start_pulse(400);
      repeat (100) begin
         @(negedge clk1M);
         seen = seen | data_oe | busy;
      end
      chk("short_quiet", 64'(seen), 64'd0);
      chk("short_pulses", 64'((n_done - d0) + (n_col - c0)), 64'd0);
      $display("short start pulse ignored=%0b", !seen);

      csum_err_inj = 1'b1;
      do_frame("csum_inj", -1, -1, got);
      csum_err_inj = 1'b0;
      chk("csum_inj_frame", 64'(got), 64'h028C010F61);
      $display("csum_inj frame 0x%010h", got);
      repeat (20) @(negedge clk1M);

      do_frame("hum_chg", 5, -1, got);
      hum = 16'h028C;
      chk("hum_chg_frame", 64'(got), 64'h028C010F9E);
      $display("hum_chg frame 0x%010h", got);
      repeat (20) @(negedge clk1M);

      do_frame("collide", -1, 12, got);
      $display("collision on bit 12 handled");
      repeat (20) @(negedge clk1M);

      start_pulse(1000);
      wait_oe(n);
      repeat (10) @(negedge clk1M);
      #100;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_oe", 64'(data_oe), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk1M);
      rst_n = 1'b1;
      repeat (5) @(negedge clk1M);
      do_frame("post_rst", -1, -1, got);
      chk("post_rst_frame", 64'(got), 64'h028C010F9E);
      $display("post-reset frame 0x%010h", got);

      chk("done_col_overlap", 64'(n_both), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
